dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target side of the CPU's load/store port.
- Accepts one read or write request per handshake, holds it for a programmable latency, then returns a single-cycle acknowledge carrying read data or an error flag.
- Sits between the CPU datapath (initiator) and on-chip storage.
- Gives the future multi-cycle/pipelined CPU a realistic, stallable memory to fetch and store against.

Parameters:
- DEPTH, 256, number of 32-bit words stored. Valid byte addresses are 0 .. 4*DEPTH-1.
- LATENCY, 3, cycles from the request-acceptance edge to the edge that raises ack_o. Legal range is 1..15; other values are illegal.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  request valid from the initiator.
- we_i  input  1  1 = write, 0 = read. Sampled with req_i.
- addr_i  input  32  byte address. Sampled with req_i.
- wdata_i  input  32  write data. Sampled with req_i.
- ready_o  output  1  responder can accept a request this cycle.
- ack_o  output  1  one-cycle response strobe.
- rdata_o  output  32  read data. Valid when ack_o=1 for a successful read.
- err_o  output  1  response error. Valid only when ack_o=1.

Behaviour:
- Clock/reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. Reset has priority over every other event at that edge.
- Reset values:
  - FSM returns to IDLE.
  - ready_o=1 from the first cycle after reset.
  - ack_o=0, err_o=0, rdata_o=32'h0.
  - Latency counter is cleared.
  - Storage array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready_o=1.
  - On an edge with req_i=1, the request is accepted and addr_i, we_i and wdata_i are captured.
  - Error check at acceptance: the request is an error if addr_i[1:0]!=0, or if addr_i[31:2] >= DEPTH.
  - Error request → RESP directly, regardless of LATENCY.
  - Valid request with LATENCY=1 → RESP.
  - Valid request otherwise → WAIT, with counter loaded to LATENCY-1.
- WAIT:
  - ready_o=0.
  - Counter decrements each edge.
  - The edge at which the counter equals 1 moves to RESP.
- Transition into RESP (valid request):
  - Write: mem[addr[31:2]] <= wdata on that same edge.
  - Read: rdata_o <= mem[addr[31:2]] on that same edge.
  - Result: ack_o is high in exactly the cycle beginning LATENCY edges after acceptance.
- Transition into RESP (error request):
  - ack_o=1 and err_o=1 in the cycle after acceptance.
  - No memory write occurs.
  - rdata_o is held at its previous value.
- RESP:
  - ack_o=1, ready_o=0, err_o as computed.
  - Always returns to IDLE on the next edge.
- Outside RESP: ack_o=0 and err_o=0.
- rdata_o holding rules:
  - Holds its value until the next successful read, or until reset.
  - Writes do not change rdata_o.
- Throughput: one transaction per LATENCY+1 cycles for valid requests, and one per 2 cycles for error requests.
- Inputs are ignored while ready_o=0. A request held by the initiator is accepted on the first IDLE edge.
- Reset mid-transaction (WAIT or the RESP-entry edge): the transaction is aborted with no ack and no memory write. The next request is accepted normally after reset deasserts.
- Read-after-write to the same address returns the newly written data.
- Highest word (addr = 4*DEPTH-4) is valid. addr = 4*DEPTH is an error.

Test Plan:
- Reset, then write addr 0x10 with data 0xDEADBEEF (LATENCY=3) → ready_o falls the cycle after acceptance; ack_o=1, err_o=0 exactly 3 edges after acceptance; ready_o=1 one cycle later.
- Read addr 0x10 after that write → ack_o after 3 edges with rdata_o=0xDEADBEEF; rdata_o still holds 0xDEADBEEF after a following write of 0x1 to 0x14.
- Read addr 0x12 (misaligned), then read 0x400 (DEPTH=256, out of range) → each gets ack_o=1, err_o=1 the cycle after acceptance; rdata_o unchanged; a subsequent read of 0x10 still returns 0xDEADBEEF.
- req_i held high continuously with alternating writes/reads to 0x3FC (last word) → exactly one acceptance every 4 cycles; no request is lost or duplicated; read returns the last written value.
- Write 0x12345678 to 0x20, then assert rst_i during WAIT → no ack; after reset, reading 0x20 returns its pre-write value; ready_o=1 the cycle after reset.
- Rebuild with LATENCY=1 → ack_o in the cycle right after acceptance; back-to-back reads complete every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with programmable response latency.
// Accepts one request per handshake and returns a single-cycle ack or error.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic          in_err;
  logic          accept;
  logic          commit;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] cur_idx;
  logic          cur_we;
  logic [31:0]   cur_wdata;

  assign in_err = (addr_i[1:0] != 2'b00) ||
                  (addr_i[31:2] >= 30'(DEPTH));

  assign accept = (state_q == IDLE) && req_i;

  // A single-cycle latency commits straight from the live inputs.
  assign cur_idx   = (state_q == IDLE) ? addr_i[AW+1:2] : idx_q;
  assign cur_we    = (state_q == IDLE) ? we_i : we_q;
  assign cur_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

  assign commit = (accept && !in_err && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));

  assign wr_en = commit && cur_we && !rst_i;
  assign rd_en = commit && !cur_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (in_err || (LATENCY == 1)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    ack_o   = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      IDLE: ready_o = 1'b1;
      RESP: begin
        ack_o = 1'b1;
        err_o = err_q;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      cnt_q   <= 4'(LATENCY - 1);
      idx_q   <= addr_i[AW+1:2];
      we_q    <= we_i;
      err_q   <= in_err;
      wdata_q <= wdata_i;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= 32'h0;
    end else if (rd_en) begin
      rdata_o <= mem[cur_idx];
    end
  end

endmodule
